serial_addsub: RTL and testbench
================================

Name: serial_addsub

Overview:
- Bit-serial N-bit adder/subtractor that computes a+b or a−b one bit per clock, LSB first, through a single full-adder cell.
- It is the sequential, area-minimal counterpart of the team's parallel ripple nbitAdder, and it adds the subtract direction.
- Operands are captured on a start handshake. The block reports the result, the carry/borrow and the signed overflow with a one-cycle done pulse.

Parameters:
- N, 8, operand and result width in bits (N ≥ 1).

Ports:
- clk    input   1   rising-edge clock
- rst    input   1   asynchronous active-high reset
- start  input   1   request a new operation; sampled only in IDLE
- sub    input   1   0 = a+b, 1 = a−b; captured with start
- a      input   N   operand A, captured with start
- b      input   N   operand B, captured with start
- busy   output  1   high while an operation is in progress (RUN state)
- done   output  1   one-cycle pulse when the result is valid
- result output  N   a±b modulo 2^N; held stable from done until the next accepted start
- cout   output  1   final carry out; for subtract, 1 = no borrow (a ≥ b unsigned)
- ovf    output  1   two's-complement signed overflow

Behaviour:
- Reset (asynchronous, immediate, valid mid-operation):
  - state=IDLE.
  - busy=0, done=0, result=0, cout=0, ovf=0.
  - Internal shift registers, carry and bit counter all cleared.
- States:
  - IDLE: waits for start.
  - RUN: processes one bit per cycle.
  - DONE: lasts exactly one cycle, then returns to IDLE.
- IDLE with start=1:
  - Latch opa=a and opb = sub ? ~b : b.
  - Set carry=sub and cnt=0. Go to RUN; busy=1 on the next cycle.
- RUN, each cycle:
  - Full-adder inputs: opa[0], opb[0], carry. Outputs: s, c.
  - opa and opb shift right by 1.
  - The result register shifts right, with s inserted at MSB.
  - carry ← c. Record cprev ← carry before the update.
  - cnt increments.
  - When cnt = N−1, go to DONE.
- DONE:
  - done=1 and busy=0.
  - cout = final carry; ovf = carry ^ cprev (carry into MSB xor carry out).
  - Both flags hold with result until the next accepted start.
- Latency:
  - start sampled at edge t; busy high for edges t+1..t+N.
  - done high for exactly 1 cycle after edge t+N+1.
  - Throughput: one operation per N+2 cycles.
- start in RUN or DONE is ignored. No queuing. Captured operands are not disturbed.
- a, b and sub may change freely after the capture edge.
- On a new start, result/cout/ovf keep their old values until they are overwritten bit-serially. Consumers use result only at or after done.
- N=1: RUN lasts a single cycle; ovf = carry-in ^ carry-out of that bit.
- Arithmetic is modulo 2^N; there is no saturation.

Decomposition:
- Shared package addsub_pkg holds:
  - state encoding localparams IDLE=2'd0, RUN=2'd1, DONE=2'd2;
  - the counter width function clog2(N).
- One sub-module, full_adder (a, b, cin → s, cout, purely combinational), instanced once.
- Reset handling, the counter and the shift registers stay in serial_addsub.

Test Plan:
- N=8, sub=0, a=2, b=2 → done after 9 cycles; result=4, cout=0, ovf=0.
- sub=1, a=33, b=10 → result=23, cout=1 (no borrow), ovf=0.
- sub=0, a=49, b=190 → result=239, cout=0, ovf=0. Then sub=1, same operands → result=115, cout=0 (borrow), ovf=0.
- sub=0, a=8'h7F, b=8'h01 → result=8'h80, ovf=1. sub=1, a=8'h80, b=8'h01 → result=8'h7F, ovf=1, cout=1.
- Pulse start again 3 cycles into RUN with different operands → ignored. First result is correct, exactly one done pulse, then a new start is accepted in IDLE.
- Assert rst mid-RUN (cycle 4) → busy, done, result, cout and ovf go to 0 immediately, without waiting for a clock edge. After release, a fresh 2+2 completes correctly with latency N+1.

Source files
------------

// File: rtl/addsub_pkg.sv
// Shared definitions for the bit-serial adder/subtractor: FSM state encoding
// and the counter-width helper.
package addsub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Ceiling log2, evaluated at elaboration time to size the bit counter.
    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = n - 1;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder; the only arithmetic cell used by serial_addsub.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial N-bit adder/subtractor: one full-adder cell processes a single
// bit per clock, LSB first, and a one-cycle done pulse marks the valid result.
module serial_addsub
    import addsub_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         sub,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] result,
    output logic         cout,
    output logic         ovf
);

    localparam int CW = (N > 1) ? clog2(N) : 1;

    state_e         state_q, state_d;
    logic [N-1:0]   opa_q, opa_d;
    logic [N-1:0]   opb_q, opb_d;
    logic [N-1:0]   res_q, res_d;
    logic           carry_q, carry_d;
    logic           cout_q, cout_d;
    logic           ovf_q, ovf_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           fa_s, fa_c;

    full_adder u_fa (
        .a    (opa_q[0]),
        .b    (opb_q[0]),
        .cin  (carry_q),
        .s    (fa_s),
        .cout (fa_c)
    );

    // NOTE: every signal gets its hold value first, so no path through the
    // case leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        res_d   = res_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        cnt_d   = cnt_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    opa_d   = a;
                    // Subtraction is a + ~b + 1: invert b and seed the carry.
                    opb_d   = sub ? ~b : b;
                    carry_d = sub;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                opa_d        = opa_q >> 1;
                opb_d        = opb_q >> 1;
                res_d        = res_q >> 1;
                res_d[N-1]   = fa_s;
                carry_d      = fa_c;
                cnt_d        = cnt_q + CW'(1);
                if (cnt_q == CW'(N - 1)) begin
                    // carry_q is the carry into the MSB on this last bit.
                    cout_d  = fa_c;
                    ovf_d   = fa_c ^ carry_q;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples its pre-edge value, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            opa_q   <= '0;
            opb_q   <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy   = (state_q == RUN);
    assign done   = (state_q == DONE);
    assign result = res_q;
    assign cout   = cout_q;
    assign ovf    = ovf_q;

endmodule

// File: tb/tb_serial_addsub.sv
// Self-checking bench for serial_addsub: directed vector table, random
// operations against an arithmetic reference model, and multi-cycle corners.
module tb_serial_addsub;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         sub;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         busy;
    logic         done;
    logic [N-1:0] result;
    logic         cout;
    logic         ovf;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    serial_addsub #(.N(N)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .sub    (sub),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result),
        .cout   (cout),
        .ovf    (ovf)
    );

    typedef struct {
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic         sub;
        logic [N-1:0] res;
        logic         cout;
        logic         ovf;
    } vec_t;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Reference: plain integer arithmetic on unsigned and signed views.
    function automatic void model(input logic [N-1:0] ma, input logic [N-1:0] mb, input logic msub,
                                  output logic [N-1:0] r, output logic c, output logic v);
        int full;
        int sr;
        int sa;
        int sb;
        sa = int'($signed(ma));
        sb = int'($signed(mb));
        if (!msub) begin
            full = int'(ma) + int'(mb);
            sr   = sa + sb;
        end else begin
            full = int'(ma) + (2 ** N) - int'(mb);
            sr   = sa - sb;
        end
        r = full[N-1:0];
        c = (full >= (2 ** N));
        v = (sr > (2 ** (N - 1)) - 1) || (sr < -(2 ** (N - 1)));
    endfunction

    // Leaves the bench at the falling edge just after the capture edge.
    task automatic launch(input logic [N-1:0] ta, input logic [N-1:0] tb_v, input logic ts);
        @(negedge clk);
        a     = ta;
        b     = tb_v;
        sub   = ts;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a     = N'($urandom);
        b     = N'($urandom);
        sub   = 1'($urandom);
    endtask

    // Counts capture edge as cycle 1; bounded so a stuck DUT cannot hang the run.
    task automatic finish_op(output int cycles, output int busy_n);
        cycles = 1;
        busy_n = busy ? 1 : 0;
        while (!done && cycles < 4 * N) begin
            @(negedge clk);
            cycles++;
            if (busy) busy_n++;
        end
    endtask

    task automatic do_op(input string name, input logic [N-1:0] ta, input logic [N-1:0] tb_v,
                         input logic ts, input logic [N-1:0] er, input logic ec, input logic ev);
        int cycles;
        int busy_n;
        launch(ta, tb_v, ts);
        finish_op(cycles, busy_n);
        check({name, " latency"}, cycles, N + 1);
        check({name, " busy_cycles"}, busy_n, N);
        check({name, " done"}, done, 1);
        check({name, " busy_at_done"}, busy, 0);
        check({name, " result"}, result, er);
        check({name, " cout"}, cout, ec);
        check({name, " ovf"}, ovf, ev);
        @(negedge clk);
        check({name, " done_pulse"}, done, 0);
        check({name, " result_hold"}, result, er);
    endtask

    initial begin
        vec_t         vecs[10];
        logic [N-1:0] ra;
        logic [N-1:0] rb;
        logic         rs;
        logic [N-1:0] er;
        logic         ec;
        logic         ev;
        int           cycles;
        int           busy_n;
        int           extra_done;

        vecs[0] = '{8'd2,   8'd2,   1'b0, 8'd4,   1'b0, 1'b0};
        vecs[1] = '{8'd33,  8'd10,  1'b1, 8'd23,  1'b1, 1'b0};
        vecs[2] = '{8'd49,  8'd190, 1'b0, 8'd239, 1'b0, 1'b0};
        vecs[3] = '{8'd49,  8'd190, 1'b1, 8'd115, 1'b0, 1'b0};
        vecs[4] = '{8'h7F,  8'h01,  1'b0, 8'h80,  1'b0, 1'b1};
        vecs[5] = '{8'h80,  8'h01,  1'b1, 8'h7F,  1'b1, 1'b1};
        vecs[6] = '{8'hFF,  8'h01,  1'b0, 8'h00,  1'b1, 1'b0};
        vecs[7] = '{8'h00,  8'h00,  1'b1, 8'h00,  1'b1, 1'b0};
        vecs[8] = '{8'h80,  8'h80,  1'b0, 8'h00,  1'b1, 1'b1};
        vecs[9] = '{8'h00,  8'h80,  1'b1, 8'h80,  1'b0, 1'b1};

        rst   = 1'b1;
        start = 1'b0;
        sub   = 1'b0;
        a     = '0;
        b     = '0;
        #1;
        check("reset busy",   busy,   0);
        check("reset done",   done,   0);
        check("reset result", result, 0);
        check("reset cout",   cout,   0);
        check("reset ovf",    ovf,    0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            do_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].sub,
                  vecs[i].res, vecs[i].cout, vecs[i].ovf);
        end

        for (int i = 0; i < 40; i++) begin
            ra = N'($urandom);
            rb = N'($urandom);
            rs = 1'($urandom);
            model(ra, rb, rs, er, ec, ev);
            do_op($sformatf("rand%0d", i), ra, rb, rs, er, ec, ev);
        end

        // A start pulse in the middle of RUN must not disturb the operation.
        launch(8'd100, 8'd27, 1'b0);
        repeat (2) @(negedge clk);
        a     = 8'd200;
        b     = 8'd99;
        sub   = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        finish_op(cycles, busy_n);
        cycles = cycles + 3;
        check("ignore latency", cycles, N + 1);
        check("ignore done",    done,   1);
        check("ignore result",  result, 8'd127);
        check("ignore cout",    cout,   0);
        check("ignore ovf",     ovf,    0);
        extra_done = 0;
        for (int i = 0; i < N + 4; i++) begin
            @(negedge clk);
            if (done || busy) extra_done++;
        end
        check("ignore single_done", extra_done, 0);
        do_op("after_ignore", 8'd200, 8'd99, 1'b1, 8'd101, 1'b1, 1'b1);

        // Asynchronous reset four cycles into RUN, away from any clock edge.
        launch(8'h5A, 8'h33, 1'b0);
        repeat (3) @(negedge clk);
        check("pre_rst busy", busy, 1);
        #2 rst = 1'b1;
        #1;
        check("async_rst busy",   busy,   0);
        check("async_rst done",   done,   0);
        check("async_rst result", result, 0);
        check("async_rst cout",   cout,   0);
        check("async_rst ovf",    ovf,    0);
        @(negedge clk);
        rst = 1'b0;
        do_op("post_rst", 8'd2, 8'd2, 1'b0, 8'd4, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
